// File: rtl/port_chk_pkg.sv
// Shared types, defaults and the expected-value transform for the port match checker.
package port_chk_pkg;

  typedef logic [7:0] port_t;

  localparam int DEF_DEPTH   = 4;
  localparam int DEF_MAX_LAT = 5;

  typedef enum logic [1:0] {IDLE, TRACK, FAIL} state_t;

  function automatic port_t expected_xform(port_t p, bit xform_en);
    if (xform_en && (p >= 8'd4)) return p + 8'd1;
    return p;
  endfunction

endpackage

// File: rtl/port_chk_fifo.sv
// In-order tracker of expected values; every resident entry ages by one per clock,
// saturating at MAX_AGE.
module port_chk_fifo
  import port_chk_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int AGE_W   = 3,
  parameter int MAX_AGE = DEF_MAX_LAT + 1,
  localparam int CNT_W  = $clog2(DEPTH + 1),
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  port_t            push_data,
  input  logic             pop,
  output port_t            head_data,
  output logic [AGE_W-1:0] head_age,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  port_t            data_q [DEPTH];
  logic [AGE_W-1:0] age_q  [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  function automatic logic [PTR_W-1:0] ptr_inc(logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  assign head_data = data_q[rd_ptr];
  assign head_age  = age_q[rd_ptr];
  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // Storage carries no reset: residency is defined purely by the pointers and count.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (push && (wr_ptr == PTR_W'(i))) begin
        data_q[i] <= push_data;
        age_q[i]  <= '0;
      end else if (age_q[i] < AGE_W'(MAX_AGE)) begin
        age_q[i]  <= age_q[i] + AGE_W'(1);
      end
    end
  end

endmodule

// File: rtl/port_match_checker.sv
// Scoreboard-in-hardware: predicts output-port values from input-port traffic and
// flags matches, mismatches, latency timeouts and tracker overflow.
module port_match_checker
  import port_chk_pkg::*;
#(
  parameter int DEPTH    = DEF_DEPTH,
  parameter int MAX_LAT  = DEF_MAX_LAT,
  parameter bit XFORM_EN = 1'b1,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_en,
  input  logic [7:0]       portin,
  input  logic             out_en,
  input  logic [7:0]       portout,
  input  logic             err_clr,
  output logic             match_pulse,
  output logic             mismatch_pulse,
  output logic             timeout_pulse,
  output logic [7:0]       exp_data,
  output logic [7:0]       got_data,
  output logic [CNT_W-1:0] pending_cnt,
  output logic             overflow,
  output logic [15:0]      match_cnt,
  output logic [15:0]      error_cnt,
  output logic             fail
);

  localparam int AGE_W   = $clog2(MAX_LAT + 2);
  localparam int MAX_AGE = MAX_LAT + 1;

  port_t            head_data;
  logic [AGE_W-1:0] head_age;
  logic [AGE_W-1:0] head_eff;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             full;
  logic             empty;
  logic             out_hit;
  logic             is_match;
  logic             is_mismatch;
  logic             is_timeout;
  logic             is_drop;
  logic             pop;
  logic             push;
  logic             any_err;
  state_t           state;

  function automatic logic [15:0] sat_inc(logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Stored age lags by one edge; the effective age is what the entry reaches at this edge,
  // so an entry pushed at this edge can never be compared at it.
  assign head_eff = (head_age >= AGE_W'(MAX_LAT)) ? AGE_W'(MAX_AGE) : head_age + AGE_W'(1);

  assign out_hit     = out_en && !empty;
  assign is_match    = out_hit && (head_eff != '0) && (head_eff <= AGE_W'(MAX_LAT))
                       && (head_data == portout);
  assign is_mismatch = out_en && !is_match;
  assign is_timeout  = !out_en && !empty && (head_eff == AGE_W'(MAX_LAT));
  assign pop         = out_hit || is_timeout;
  assign push        = in_en && (!full || pop);
  assign is_drop     = in_en && full && !pop;
  assign any_err     = is_mismatch || is_timeout || is_drop;

  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + CNT_W'(1);
    else if (pop && !push) count_next = count - CNT_W'(1);
  end

  port_chk_fifo #(
    .DEPTH   (DEPTH),
    .AGE_W   (AGE_W),
    .MAX_AGE (MAX_AGE)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (expected_xform(portin, XFORM_EN)),
    .pop       (pop),
    .head_data (head_data),
    .head_age  (head_age),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  assign pending_cnt = count;
  assign fail        = (state == FAIL);

  // Result stage: all event outputs register one cycle after the sampling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_pulse    <= 1'b0;
      mismatch_pulse <= 1'b0;
      timeout_pulse  <= 1'b0;
      exp_data       <= '0;
      got_data       <= '0;
      overflow       <= 1'b0;
      match_cnt      <= '0;
      error_cnt      <= '0;
      state          <= IDLE;
    end else begin
      match_pulse    <= is_match;
      mismatch_pulse <= is_mismatch;
      timeout_pulse  <= is_timeout;

      if (out_en) begin
        exp_data <= out_hit ? head_data : 8'd0;
        got_data <= portout;
      end else if (is_timeout) begin
        exp_data <= head_data;
        got_data <= 8'd0;
      end

      if (is_match) match_cnt <= sat_inc(match_cnt);
      if (any_err)  error_cnt <= sat_inc(error_cnt);

      if (err_clr)      overflow <= 1'b0;
      else if (is_drop) overflow <= 1'b1;

      if (err_clr)              state <= (count_next == '0) ? IDLE : TRACK;
      else if (any_err)         state <= FAIL;
      else if (state != FAIL)   state <= (count_next == '0) ? IDLE : TRACK;
    end
  end

endmodule

// File: doc/port_match_checker.md
PORT_MATCH_CHECKER -- requirements
Module: port_match_checker

Interface
REQ-001 Parameter DEPTH, default 4: maximum outstanding input transactions tracked.
REQ-002 Parameter MAX_LAT, default 5: maximum input-to-output latency, in clk cycles.
REQ-003 Parameter XFORM_EN, default 1: 1 = expected = (portin < 4) ? portin : portin + 1 (mod 256); 0 = expected = portin.
REQ-004 One clock; reset is asynchronous and active-high; ports are clk and rst.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 in_en  input  1  input-side transaction valid.
REQ-008 portin  input  8  input-side data, sampled when in_en=1.
REQ-009 out_en  input  1  output-side transaction valid.
REQ-010 portout  input  8  output-side data, sampled when out_en=1.
REQ-011 err_clr  input  1  clears overflow and the FAIL state.
REQ-012 match_pulse  output  1  one-cycle pulse: output matched the expected value.
REQ-013 mismatch_pulse  output  1  one-cycle pulse: wrong data, early output, or output with nothing pending.
REQ-014 timeout_pulse  output  1  one-cycle pulse: pending entry exceeded MAX_LAT.
REQ-015 exp_data / got_data  output  8 each  expected and received values of the last compare or timeout (got_data = 0 on timeout).
REQ-016 pending_cnt  output  $clog2(DEPTH+1)  number of outstanding entries.
REQ-017 overflow  output  1  sticky; an in_en was dropped because the tracker was full.
REQ-018 match_cnt / error_cnt  output  16 each  saturating event counters.
REQ-019 fail  output  1  high while the state machine is in FAIL.

Function
REQ-020 At each sampled in_en, push {expected(portin), age=0} to the in-order tracker.
REQ-021 Every edge, the age of every resident entry increments, saturating at MAX_LAT+1.
REQ-022 When out_en is sampled and the tracker is non-empty: pop the head and compare.
- Head age in 1..MAX_LAT and data equal -> match.
- Otherwise -> mismatch.
REQ-023 out_en sampled with the tracker empty -> mismatch, exp_data=0, got_data=portout.
REQ-024 An entry pushed at the same edge is never eligible for an out_en at that edge; with the tracker empty, simultaneous in_en/out_en yields a mismatch plus a push.
REQ-025 If the head age equals MAX_LAT and out_en is not sampled at that edge, the head is popped and a timeout is flagged; at most one timeout per edge.
REQ-026 Push while full and no pop at the same edge -> entry dropped, overflow set; push and pop at the same edge while full -> both performed, no overflow.
REQ-027 Pulses and exp_data/got_data are registered and valid in the cycle after the sampling edge (latency 1).
REQ-028 match_cnt increments per match; error_cnt increments per mismatch, timeout, or overflow drop; both saturate at 16'hFFFF.
REQ-029 State machine, per edge:
- IDLE (empty) -> TRACK on push.
- TRACK -> IDLE when the tracker becomes empty.
- any -> FAIL on mismatch, timeout, or drop.
- FAIL -> IDLE/TRACK on err_clr=1.
REQ-030 In FAIL, tracking, comparison, and counting continue; only fail is asserted.
REQ-031 err_clr takes priority over an error at the same edge; overflow is cleared.

Reset
REQ-032 While rst=1:
- Tracker emptied; state = IDLE.
- All pulses, exp_data, got_data, pending_cnt, overflow, match_cnt, error_cnt, fail = 0.
REQ-033 Reset mid-operation discards all pending entries; no pulse is emitted for them after release.
REQ-034 The first sampled in_en after rst deasserts is pushed normally.

Structure
REQ-035 Package port_chk_pkg holds:
- typedef port_t (logic [7:0]).
- Default DEPTH and MAX_LAT.
- State enum {IDLE, TRACK, FAIL}.
- Function expected_xform(port_t, bit).
REQ-036 Sub-module port_chk_fifo: DEPTH-entry in-order store of {data, age}, with push/pop/head/count and per-entry age increment.

Verification
REQ-037 portin=2 with in_en at edge t, portout=2 with out_en at t+1 -> match_pulse in the next cycle, exp_data=got_data=2, match_cnt=1.
REQ-038 XFORM_EN=1, portin=5; portout=6 -> match; a second run with portout=5 -> mismatch_pulse, exp_data=6, got_data=5, fail=1.
REQ-039 portin=3 with in_en at t, no out_en -> timeout_pulse after edge t+5, exp_data=3, pending_cnt=0, error_cnt=1.
REQ-040 Five consecutive in_en with no out_en, DEPTH=4 -> pending_cnt=4, overflow=1, error_cnt=1; err_clr -> overflow=0, fail=0.
REQ-041 out_en with portout=9 and nothing pending -> mismatch_pulse, exp_data=0, got_data=9.
REQ-042 Two entries pending, rst pulsed -> all outputs 0; no timeout pulse follows.
